// File: rtl/link_sync_ctrl.sv
// link_sync_ctrl: drains the deserializer FIFO one bit per cycle, hunts for
// K28.5 at any bit offset, frames aligned 10-bit symbols and qualifies lock.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   HUNT   | sliding comma search at every bit; no words emitted
//   ACQ    | boundary fixed by the last comma; counting aligned commas
//   LOCKED | link qualified; errors counted, clean words decay the count
module link_sync_ctrl #(
  parameter int unsigned ACQ_COMMAS = 3,
  parameter int unsigned LOSS_ERRS  = 4,
  parameter int unsigned GOOD_WORDS = 16
) (
  input  logic       i_Rclk,
  input  logic       i_Rrst,
  input  logic       i_empty,
  output logic       o_R_en,
  input  logic       i_FIFO_Out,
  input  logic       i_Code_Err,
  output logic [9:0] o_Word,
  output logic       o_Word_Valid,
  output logic       o_Is_Comma,
  output logic       o_Locked,
  output logic [1:0] o_State,
  output logic       o_Slip
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] K28P5_RDN = 10'b0101111100;
  localparam logic [9:0] K28P5_RDP = 10'b1010000011;
  localparam logic [3:0] ACQ_LIM   = 4'(ACQ_COMMAS);
  localparam logic [3:0] LOSS_LIM  = 4'(LOSS_ERRS);
  localparam logic [7:0] GOOD_LIM  = 8'(GOOD_WORDS);

  state_t     r_state;
  logic       r_bit_v;
  logic [9:0] r_sr;
  logic [3:0] r_bit_cnt;
  logic [3:0] r_acq_cnt;
  logic [3:0] r_err_cnt;
  logic [7:0] r_good_cnt;
  logic [9:0] r_word;
  logic       r_word_valid;
  logic       r_is_comma;
  logic       r_slip;

  state_t     w_state_nxt;
  logic [9:0] w_sr_nxt;
  logic [3:0] w_bit_cnt_nxt;
  logic [3:0] w_acq_cnt_nxt;
  logic [3:0] w_err_cnt_nxt;
  logic [7:0] w_good_cnt_nxt;
  logic [9:0] w_word_nxt;
  logic       w_word_valid_nxt;
  logic       w_is_comma_nxt;
  logic       w_slip_nxt;

  logic [9:0] w_win;
  logic       w_comma;
  logic       w_boundary;
  logic       w_misaligned;
  logic       w_err_evt;

  // Read enable is combinational so a bit can be requested every cycle;
  // reset overrides a non-empty FIFO.
  assign o_R_en = ~i_empty & ~i_Rrst;

  // The window includes the bit arriving this cycle, so a comma is seen on
  // the same edge that consumes its last bit.
  assign w_win        = {i_FIFO_Out, r_sr[9:1]};
  assign w_comma      = r_bit_v & ((w_win == K28P5_RDN) | (w_win == K28P5_RDP));
  assign w_boundary   = r_bit_v & (r_bit_cnt == 4'd9);
  assign w_misaligned = w_comma & ~w_boundary;
  // Both error sources together still count as a single event.
  assign w_err_evt    = w_misaligned | i_Code_Err;

  // State, shift register, counters and registered word outputs.
  always_ff @(posedge i_Rclk) begin
    if (i_Rrst) begin
      r_state      <= ST_HUNT;
      r_bit_v      <= 1'b0;
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_acq_cnt    <= '0;
      r_err_cnt    <= '0;
      r_good_cnt   <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_is_comma   <= 1'b0;
      r_slip       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_v      <= o_R_en;
      r_sr         <= w_sr_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_acq_cnt    <= w_acq_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_good_cnt   <= w_good_cnt_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_is_comma   <= w_is_comma_nxt;
      r_slip       <= w_slip_nxt;
    end
  end

  // Next-state, framing and lock-qualification logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_sr_nxt         = r_sr;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_acq_cnt_nxt    = r_acq_cnt;
    w_err_cnt_nxt    = r_err_cnt;
    w_good_cnt_nxt   = r_good_cnt;
    w_word_nxt       = r_word;
    w_word_valid_nxt = 1'b0;
    w_is_comma_nxt   = r_is_comma;
    w_slip_nxt       = 1'b0;

    // With no valid bit this cycle nothing below can fire except a code
    // error, because every other event is qualified by r_bit_v.
    if (r_bit_v) begin
      w_sr_nxt      = w_win;
      w_bit_cnt_nxt = (r_bit_cnt == 4'd9) ? 4'd0 : r_bit_cnt + 4'd1;
    end

    // Words leave only from the framed states.
    if (w_boundary && (r_state != ST_HUNT)) begin
      w_word_nxt       = w_win;
      w_word_valid_nxt = 1'b1;
      w_is_comma_nxt   = w_comma;
    end

    case (r_state)
      ST_HUNT: begin
        w_bit_cnt_nxt = 4'd0;
        if (w_comma) begin
          w_state_nxt   = ST_ACQ;
          w_acq_cnt_nxt = 4'd1;
          w_slip_nxt    = 1'b1;
        end
      end

      ST_ACQ: begin
        if (w_misaligned) begin
          w_state_nxt   = ST_HUNT;
          w_bit_cnt_nxt = 4'd0;
          w_slip_nxt    = 1'b1;
        end else if (i_Code_Err) begin
          // Abandons the candidate even if this word was the last comma needed.
          w_state_nxt   = ST_HUNT;
          w_bit_cnt_nxt = 4'd0;
        end else if (w_comma) begin
          if ((r_acq_cnt + 4'd1) >= ACQ_LIM) begin
            w_state_nxt    = ST_LOCKED;
            w_err_cnt_nxt  = 4'd0;
            w_good_cnt_nxt = 8'd0;
          end else begin
            w_acq_cnt_nxt = r_acq_cnt + 4'd1;
          end
        end
      end

      ST_LOCKED: begin
        if (w_err_evt) begin
          // An error on the word that would have finished the clean run wins.
          w_good_cnt_nxt = 8'd0;
          if ((r_err_cnt + 4'd1) >= LOSS_LIM) begin
            w_state_nxt   = ST_HUNT;
            w_bit_cnt_nxt = 4'd0;
            w_slip_nxt    = 1'b1;
          end else begin
            w_err_cnt_nxt = r_err_cnt + 4'd1;
          end
        end else if (w_boundary) begin
          if ((r_good_cnt + 8'd1) >= GOOD_LIM) begin
            w_err_cnt_nxt  = 4'd0;
            w_good_cnt_nxt = 8'd0;
          end else begin
            w_good_cnt_nxt = r_good_cnt + 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt   = ST_HUNT;
        w_bit_cnt_nxt = 4'd0;
      end
    endcase
  end

  assign o_Word       = r_word;
  assign o_Word_Valid = r_word_valid;
  assign o_Is_Comma   = r_is_comma;
  assign o_Locked     = (r_state == ST_LOCKED);
  assign o_State      = r_state;
  assign o_Slip       = r_slip;

endmodule
